md_pad_reader: RTL and testbench

- Host-side poller for a physical Mega Drive 3/6-button pad on a DB9/SNAC port.
- Drives the TH select line through the standard 8-phase TH toggle sequence and samples the six pad data lines.
- Decodes pad presence, 3- vs 6-button type and all 12 buttons.
- Presents results as an atomic active-high button word to the core's joystick mux.

---
 rtl/md_pad_pkg.sv | 42 ++++
 rtl/pad_sync.sv | 21 ++
 rtl/md_pad_reader.sv | 143 ++++++++++++++
 tb/tb_md_pad_reader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/md_pad_pkg.sv
// Shared types and constants for the Mega Drive pad poller.
`timescale 1ns/1ps
package md_pad_pkg;

  // S0..S7 encode the phase number directly in the low three bits.
  typedef enum logic [3:0] {
    PH_S0     = 4'd0,
    PH_S1     = 4'd1,
    PH_S2     = 4'd2,
    PH_S3     = 4'd3,
    PH_S4     = 4'd4,
    PH_S5     = 4'd5,
    PH_S6     = 4'd6,
    PH_S7     = 4'd7,
    PH_IDLE   = 4'd8,
    PH_DECODE = 4'd9
  } phase_t;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  localparam int D_UP    = 0;
  localparam int D_DOWN  = 1;
  localparam int D_LEFT  = 2;
  localparam int D_RIGHT = 3;
  localparam int D_BA    = 4;
  localparam int D_CS    = 5;

  // Bit n is the TH level driven during phase Sn.
  localparam logic [7:0] TH_PHASE = 8'b0101_0101;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the asynchronous pad data lines.
`timescale 1ns/1ps
module pad_sync #(
  parameter int DATA_W = 6
) (
  input  logic              CLK,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] d_p0;
  logic [DATA_W-1:0] d_p1;

  always_ff @(posedge CLK) begin
    d_p0 <= d;
    d_p1 <= d_p0;
  end

  assign q = d_p1;

endmodule

// File: rtl/md_pad_reader.sv
// Polls a Mega Drive 3/6-button pad with the 8-phase TH sequence and
// publishes presence, pad type and a pressed-high button word.
`timescale 1ns/1ps
module md_pad_reader
  import md_pad_pkg::*;
#(
  parameter int SETTLE = 16,
  parameter int POLL   = 16384
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        FORCE3,
  input  logic [5:0]  D,
  output logic        TH,
  output logic [11:0] BTN,
  output logic        PRESENT,
  output logic        SIX_BTN,
  output logic        VALID
);

  localparam int TMR_W = $clog2((POLL > SETTLE ? POLL : SETTLE) + 1);
  localparam logic [TMR_W-1:0] POLL_END   = TMR_W'(POLL - 1);
  localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE - 1);

  phase_t           state;
  logic [TMR_W-1:0] tmr;
  logic             f3_path;
  logic [5:0]       d_sync;
  logic [5:0]       s0_q;
  logic [3:0]       s1_q;   // {START, A, line3, line2}
  logic [3:0]       s5_q;
  logic [3:0]       s6_q;
  logic [3:0]       s7_q;
  logic [2:0]       ph;
  logic             settle_done;
  logic             present_w;
  logic             six_w;

  pad_sync #(.DATA_W(6)) u_sync (
    .CLK (CLK),
    .d   (D),
    .q   (d_sync)
  );

  function automatic logic [11:0] decode_btn(input logic [5:0] s0, input logic [3:0] s1,
                                             input logic [3:0] s6, input logic six);
    logic [11:0] b;
    b           = '0;
    b[BTN_UP]    = ~s0[D_UP];
    b[BTN_DOWN]  = ~s0[D_DOWN];
    b[BTN_LEFT]  = ~s0[D_LEFT];
    b[BTN_RIGHT] = ~s0[D_RIGHT];
    b[BTN_B]     = ~s0[D_BA];
    b[BTN_C]     = ~s0[D_CS];
    b[BTN_A]     = ~s1[2];
    b[BTN_START] = ~s1[3];
    if (six) begin
      b[BTN_Z]    = ~s6[0];
      b[BTN_Y]    = ~s6[1];
      b[BTN_X]    = ~s6[2];
      b[BTN_MODE] = ~s6[3];
    end
    return b;
  endfunction

  assign ph          = state[2:0];
  assign settle_done = ~state[3] & CE & (tmr == SETTLE_END);
  assign present_w   = (s1_q[1:0] == 2'b00);
  assign six_w       = present_w & ~f3_path & (s5_q == 4'b0000) & (s7_q == 4'b1111);

  // Phase sample capture (data path, no reset)
  always_ff @(posedge CLK) begin
    if (settle_done) begin
      case (ph)
        3'd0:    s0_q <= d_sync;
        3'd1:    s1_q <= d_sync[5:2];
        3'd5:    s5_q <= d_sync[3:0];
        3'd6:    s6_q <= d_sync[3:0];
        3'd7:    s7_q <= d_sync[3:0];
        default: ;
      endcase
    end
  end

  // Phase sequencer and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= PH_IDLE;
      tmr     <= '0;
      f3_path <= 1'b0;
      TH      <= 1'b1;
      BTN     <= '0;
      PRESENT <= 1'b0;
      SIX_BTN <= 1'b0;
      VALID   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        PH_IDLE: begin
          TH <= 1'b1;
          if (CE) begin
            if (tmr == POLL_END) begin
              tmr   <= '0;
              state <= PH_S0;
              TH    <= TH_PHASE[0];
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end
        PH_DECODE: begin
          state   <= PH_IDLE;
          TH      <= 1'b1;
          VALID   <= 1'b1;
          PRESENT <= present_w;
          SIX_BTN <= six_w;
          BTN     <= present_w ? decode_btn(s0_q, s1_q, s6_q, six_w) : 12'h000;
        end
        default: begin
          if (CE) begin
            if (tmr == SETTLE_END) begin
              tmr <= '0;
              if (ph == 3'd3 && FORCE3) begin
                f3_path <= 1'b1;
                state   <= PH_DECODE;
              end else if (ph == 3'd7) begin
                f3_path <= 1'b0;
                state   <= PH_DECODE;
              end else begin
                state <= phase_t'({1'b0, ph + 3'd1});
                TH    <= TH_PHASE[ph + 3'd1];
              end
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_pad_reader.sv
// Directed bench for md_pad_reader against a bus-functional Mega Drive pad.
`timescale 1ns/1ps
module tb_md_pad_reader;

  localparam int SETTLE = 4;
  localparam int POLL   = 64;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CE;
  logic        FORCE3;
  logic [5:0]  D;
  logic        TH;
  logic [11:0] BTN;
  logic        PRESENT;
  logic        SIX_BTN;
  logic        VALID;

  int          checks = 0;
  int          failures = 0;
  int          kind;      // 0 = no pad, 1 = 3-button, 2 = 6-button
  logic [11:0] pressed;   // {MODE,Z,Y,X,START,C,B,A,RIGHT,LEFT,DOWN,UP}
  int          n;
  logic [15:0] seq;

  always #5 CLK = ~CLK;

  md_pad_reader #(.SETTLE(SETTLE), .POLL(POLL)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .CE      (CE),
    .FORCE3  (FORCE3),
    .D       (D),
    .TH      (TH),
    .BTN     (BTN),
    .PRESENT (PRESENT),
    .SIX_BTN (SIX_BTN),
    .VALID   (VALID)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pad_lines(input int ph, input int k, input logic [11:0] p);
    logic [5:0] g0, g1, g5, g6, g7;
    g0 = ~{p[6], p[5], p[3], p[2], p[1], p[0]};
    g1 = ~{p[7], p[4], 1'b1, 1'b1, p[1], p[0]};
    g5 = {~p[7], ~p[4], 4'b0000};
    g6 = ~{p[6], p[5], p[11], p[8], p[9], p[10]};
    g7 = {~p[7], ~p[4], 4'b1111};
    if (k == 0) return 6'h3F;
    case (ph)
      1, 3:    return g1;
      5:       return (k == 2) ? g5 : g1;
      6:       return (k == 2) ? g6 : g0;
      7:       return (k == 2) ? g7 : g1;
      default: return g0;
    endcase
  endfunction

  // Pad: counts TH transitions, forgets them after a long TH-high stretch
  initial begin
    int   e;
    int   hi;
    logic th_prev;
    e = 0;
    hi = 0;
    th_prev = 1'b1;
    D = 6'h3F;
    forever begin
      @(negedge CLK);
      if (TH !== th_prev) e++;
      th_prev = TH;
      if (TH === 1'b1) hi++;
      else hi = 0;
      if (hi >= 32) e = 0;
      D = pad_lines(e, kind, pressed);
    end
  end

  task automatic wait_valid(output int cnt, output logic [15:0] ths);
    logic last;
    cnt  = 0;
    ths  = {15'd0, TH};
    last = TH;
    while (cnt < 400) begin
      @(posedge CLK);
      #1;
      cnt++;
      if (TH !== last) begin
        ths  = {ths[14:0], TH};
        last = TH;
      end
      if (VALID === 1'b1) break;
    end
  endtask

  initial begin
    RESET   = 1'b1;
    CE      = 1'b1;
    FORCE3  = 1'b0;
    kind    = 2;
    pressed = 12'h000;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_th", {31'd0, TH}, 32'd1);
    chk("rst_btn", {20'd0, BTN}, 32'd0);
    chk("rst_present", {31'd0, PRESENT}, 32'd0);
    chk("rst_six", {31'd0, SIX_BTN}, 32'd0);
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // 6-button pad, nothing pressed
    wait_valid(n, seq);
    chk("f1_latency", n, 32'd97);
    chk("f1_th_seq", {16'd0, seq}, 32'h155);
    chk("f1_present", {31'd0, PRESENT}, 32'd1);
    chk("f1_six", {31'd0, SIX_BTN}, 32'd1);
    chk("f1_btn", {20'd0, BTN}, 32'h000);
    @(posedge CLK);
    #1;
    chk("f1_valid_pulse", {31'd0, VALID}, 32'd0);

    // START + Z + LEFT
    pressed = 12'h484;
    wait_valid(n, seq);
    chk("f2_latency", n, 32'd96);
    chk("f2_btn", {20'd0, BTN}, 32'h484);
    chk("f2_six", {31'd0, SIX_BTN}, 32'd1);

    // 3-button pad, A + UP
    kind    = 1;
    pressed = 12'h011;
    wait_valid(n, seq);
    chk("f3_latency", n, 32'd97);
    chk("f3_present", {31'd0, PRESENT}, 32'd1);
    chk("f3_six", {31'd0, SIX_BTN}, 32'd0);
    chk("f3_btn", {20'd0, BTN}, 32'h011);

    // No pad: lines float high
    kind    = 0;
    pressed = 12'h000;
    wait_valid(n, seq);
    chk("f4_latency", n, 32'd97);
    chk("f4_present", {31'd0, PRESENT}, 32'd0);
    chk("f4_six", {31'd0, SIX_BTN}, 32'd0);
    chk("f4_btn", {20'd0, BTN}, 32'h000);

    // FORCE3 on a 6-button pad, X + B pressed
    kind    = 2;
    FORCE3  = 1'b1;
    pressed = 12'h120;
    wait_valid(n, seq);
    chk("f5_latency", n, 32'd81);
    chk("f5_present", {31'd0, PRESENT}, 32'd1);
    chk("f5_six", {31'd0, SIX_BTN}, 32'd0);
    chk("f5_btn", {20'd0, BTN}, 32'h020);

    // Reset asserted during S5, then a clean frame with C + MODE
    FORCE3  = 1'b0;
    pressed = 12'h840;
    repeat (86) @(posedge CLK);
    #2;
    chk("f6_th_in_s5", {31'd0, TH}, 32'd0);
    RESET = 1'b1;
    #1;
    chk("f6_rst_th", {31'd0, TH}, 32'd1);
    chk("f6_rst_btn", {20'd0, BTN}, 32'd0);
    chk("f6_rst_present", {31'd0, PRESENT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    wait_valid(n, seq);
    chk("f6_latency", n, 32'd97);
    chk("f6_present", {31'd0, PRESENT}, 32'd1);
    chk("f6_six", {31'd0, SIX_BTN}, 32'd1);
    chk("f6_btn", {20'd0, BTN}, 32'h840);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
